// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK frame conditioning path: axis type,
// joystick centre and the bit positions of each field inside a 40-bit frame.
package jstk_pkg;

    localparam int JSTK_AXIS_W  = 10;
    localparam int JSTK_FRAME_W = 40;
    localparam int JSTK_CENTER  = 512;

    // X and Y are split across two bytes each; buttons sit in the last byte.
    localparam int JSTK_X_LO_MSB = 39;
    localparam int JSTK_X_LO_LSB = 32;
    localparam int JSTK_X_HI_MSB = 25;
    localparam int JSTK_X_HI_LSB = 24;
    localparam int JSTK_Y_LO_MSB = 23;
    localparam int JSTK_Y_LO_LSB = 16;
    localparam int JSTK_Y_HI_MSB = 9;
    localparam int JSTK_Y_HI_LSB = 8;
    localparam int JSTK_BTN_MSB  = 1;
    localparam int JSTK_BTN_LSB  = 0;

    typedef logic [JSTK_AXIS_W-1:0] axis_t;

endpackage

// File: rtl/jstk_axis_avg.sv
// One axis of the S1 stage: power-of-two moving average with first-frame priming.
// With JSTK_FILTER_AVG_EN undefined this collapses to a plain sample register.
module jstk_axis_avg
    import jstk_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_valid,
    input  axis_t i_sample,
    output axis_t o_value
);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg_log2
        $error("jstk_axis_avg: AVG_LOG2 must be 1..4");
    end

`ifdef JSTK_FILTER_AVG_EN
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = JSTK_AXIS_W + AVG_LOG2;

    axis_t                r_hist [DEPTH];
    logic [SUM_W-1:0]     r_sum;
    logic [AVG_LOG2-1:0]  r_ptr;
    logic                 r_primed;

    // r_ptr always names the oldest slot; its width makes it wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_ptr    <= '0;
            r_sum    <= '0;
        end else if (i_valid) begin
            if (!r_primed) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_hist[i] <= i_sample;
                end
                r_sum    <= SUM_W'(i_sample) << AVG_LOG2;
                r_ptr    <= '0;
                r_primed <= 1'b1;
            end else begin
                r_hist[r_ptr] <= i_sample;
                r_sum         <= r_sum - SUM_W'(r_hist[r_ptr]) + SUM_W'(i_sample);
                r_ptr         <= r_ptr + 1'b1;
            end
        end
    end

    assign o_value = axis_t'(r_sum >> AVG_LOG2);
`else
    axis_t r_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= axis_t'(JSTK_CENTER);
        end else if (i_valid) begin
            r_sample <= i_sample;
        end
    end

    assign o_value = r_sample;
`endif

endmodule

// File: rtl/jstk_frame_filter.sv
// PmodJSTK frame conditioning: S0 capture/unpack, S1 axis averaging, S2 deadzone,
// button debounce and output register. Averaging enabled by JSTK_FILTER_AVG_EN.
module jstk_frame_filter
    import jstk_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int DEADZONE   = 64,
    parameter int BTN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic [39:0] frame_in,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic [1:0]  buttons,
    output logic        dir_left,
    output logic        dir_right,
    output logic        dir_up,
    output logic        dir_down,
    output logic        out_valid,
    output logic [7:0]  frame_count
);

    if (DEADZONE < 0 || DEADZONE > 511 || BTN_FRAMES < 1 || BTN_FRAMES > 7) begin : g_bad_param
        $error("jstk_frame_filter: DEADZONE or BTN_FRAMES out of range");
    end

    localparam logic [10:0] THR_HI   = 11'(JSTK_CENTER + DEADZONE);
    localparam logic [10:0] THR_LO   = 11'(JSTK_CENTER - DEADZONE);
    localparam logic [2:0]  CNT_LAST = 3'(BTN_FRAMES - 1);

    // ---------------- S0: edge detect, capture, unpack ----------------
    logic  r_ss_q;
    logic  r_s0_valid;
    axis_t r_s0_x;
    axis_t r_s0_y;
    logic [1:0] r_s0_btn;
    logic  w_frame;
    logic  w_unused_bits;

    assign w_frame       = ss & ~r_ss_q;
    assign w_unused_bits = ^{frame_in[31:26], frame_in[15:10], frame_in[7:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_q     <= 1'b1;
            r_s0_valid <= 1'b0;
        end else begin
            r_ss_q     <= ss;
            r_s0_valid <= w_frame;
            if (w_frame) begin
                r_s0_x   <= {frame_in[JSTK_X_HI_MSB:JSTK_X_HI_LSB], frame_in[JSTK_X_LO_MSB:JSTK_X_LO_LSB]};
                r_s0_y   <= {frame_in[JSTK_Y_HI_MSB:JSTK_Y_HI_LSB], frame_in[JSTK_Y_LO_MSB:JSTK_Y_LO_LSB]};
                r_s0_btn <= frame_in[JSTK_BTN_MSB:JSTK_BTN_LSB];
            end
        end
    end

    // ---------------- S1: averaging (inside jstk_axis_avg) ----------------
    logic       r_s1_valid;
    logic [1:0] r_s1_btn;
    axis_t      w_x_filt;
    axis_t      w_y_filt;

    jstk_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_s0_valid),
        .i_sample (r_s0_x),
        .o_value  (w_x_filt)
    );

    jstk_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_s0_valid),
        .i_sample (r_s0_y),
        .o_value  (w_y_filt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_btn <= r_s0_btn;
            end
        end
    end

    // ---------------- S2: debounce, deadzone, output register ----------------
    logic [2:0] r_btn_cnt  [2];
    logic [2:0] w_cnt_next [2];
    logic [1:0] w_btn_next;
    logic [1:0] w_btn_same;
    logic [1:0] w_btn_fire;

    // The output flips only once a differing raw value has been seen BTN_FRAMES frames in a row.
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        assign w_btn_same[gi] = (r_s1_btn[gi] == buttons[gi]);
        assign w_btn_fire[gi] = !w_btn_same[gi] && (r_btn_cnt[gi] == CNT_LAST);
        assign w_btn_next[gi] = w_btn_fire[gi] ? r_s1_btn[gi] : buttons[gi];
        assign w_cnt_next[gi] = (w_btn_same[gi] || w_btn_fire[gi]) ? 3'd0 : r_btn_cnt[gi] + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos        <= 10'(JSTK_CENTER);
            ypos        <= 10'(JSTK_CENTER);
            buttons     <= 2'b00;
            dir_left    <= 1'b0;
            dir_right   <= 1'b0;
            dir_up      <= 1'b0;
            dir_down    <= 1'b0;
            out_valid   <= 1'b0;
            frame_count <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                r_btn_cnt[i] <= 3'd0;
            end
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                xpos        <= w_x_filt;
                ypos        <= w_y_filt;
                dir_right   <= {1'b0, w_x_filt} > THR_HI;
                dir_left    <= {1'b0, w_x_filt} < THR_LO;
                dir_up      <= {1'b0, w_y_filt} > THR_HI;
                dir_down    <= {1'b0, w_y_filt} < THR_LO;
                buttons     <= w_btn_next;
                frame_count <= frame_count + 8'd1;
                for (int i = 0; i < 2; i++) begin
                    r_btn_cnt[i] <= w_cnt_next[i];
                end
            end
        end
    end

endmodule
